// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: request-side sequencer for a 2**AW x DW memory with a one-cycle
// registered read. Accepts single-beat writes and multi-beat reads over a
// valid/ready request channel and returns read beats over a valid/ready
// response channel. Writes to the low CMD_WORDS addresses are dropped while
// cmd_lock is high.
module mem_req_ctrl #(
  parameter int unsigned AW        = 4,
  parameter int unsigned DW        = 8,
  parameter int unsigned CMD_WORDS = 4
) (
  input  logic          clk,
  input  logic          rst,
  // request channel
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_wr,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  input  logic [AW-1:0] req_len,
  input  logic          cmd_lock,
  // response channel
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_last,
  output logic          err,
  // memory pins
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
);

  // One extra bit so CMD_WORDS == 2**AW still compares correctly.
  localparam int unsigned LIM_W = AW + 1;
  localparam logic [LIM_W-1:0] CMD_LIM = LIM_W'(CMD_WORDS);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WRITE   = 3'd1,
    RD_ADDR = 3'd2,
    RD_CAPT = 3'd3,
    RD_RSP  = 3'd4
  } state_t;

  state_t        state_q;
  logic [AW-1:0] addr_q;
  logic [AW-1:0] cnt_q;
  logic          mem_wr_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_din_q;
  logic          rsp_valid_q;
  logic [DW-1:0] rsp_rdata_q;
  logic          rsp_last_q;
  logic          err_q;

  logic          cmd_hit;
  logic [AW-1:0] addr_inc;

  // Incoming write targets the protected command region.
  assign cmd_hit  = ({1'b0, req_addr} < CMD_LIM);
  // Next burst address, wrapping modulo 2**AW.
  assign addr_inc = addr_q + AW'(1);

  // Ready only in IDLE and never while reset is applied.
  assign req_ready = (state_q == IDLE) && !rst;

  // Controller FSM with registered memory and response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      // Write strobe and error are single-cycle pulses.
      mem_wr_q <= 1'b0;
      err_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            addr_q     <= req_addr;
            mem_addr_q <= req_addr;
            if (req_wr) begin
              mem_din_q <= req_wdata;
              // Lock is sampled at acceptance; a blocked write only flags err.
              if (cmd_lock && cmd_hit) begin
                err_q <= 1'b1;
              end else begin
                mem_wr_q <= 1'b1;
              end
              state_q <= WRITE;
            end else begin
              cnt_q   <= req_len;
              state_q <= RD_ADDR;
            end
          end
        end
        WRITE: begin
          state_q <= IDLE;
        end
        RD_ADDR: begin
          // Address is on the pins this cycle; memory registers it at the edge.
          state_q <= RD_CAPT;
        end
        RD_CAPT: begin
          rsp_rdata_q <= mem_dout;
          rsp_valid_q <= 1'b1;
          rsp_last_q  <= (cnt_q == '0);
          state_q     <= RD_RSP;
        end
        RD_RSP: begin
          // Beat held stable until the consumer takes it.
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            if (rsp_last_q) begin
              state_q <= IDLE;
            end else begin
              addr_q     <= addr_inc;
              mem_addr_q <= addr_inc;
              cnt_q      <= cnt_q - AW'(1);
              state_q    <= RD_ADDR;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_din   = mem_din_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_last  = rsp_last_q;
  assign err       = err_q;

endmodule
